// File: rtl/step_motor_pkg.sv
// Shared definitions for the step/encoder timing blocks: counter width,
// system clock rate, default stall timeout and the period meter FSM states.
package step_motor_pkg;

  // Default width of interval counters and period values
  localparam int STEP_CNT_WIDTH = 32;

  // System clock frequency in Hz
  localparam int unsigned CLK_HZ = 32'd50_000_000;

  // One second of clk cycles: a sensible stall timeout for slow motors
  localparam logic [STEP_CNT_WIDTH-1:0] DEFAULT_TIMEOUT_CYCLES = STEP_CNT_WIDTH'(CLK_HZ);

  // Period meter states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // disabled, counter cleared
    ARM     = 2'd1,  // enabled, waiting for the first reference edge
    MEASURE = 2'd2,  // counting cycles since the last edge
    STALL   = 2'd3   // timeout or saturation hit, waiting for the next edge
  } meter_state_t;

endpackage

// File: rtl/step_period_meter_if.sv
// Signal bundle between a pulse source / controller and the period meter.
// The master drives the pulse, enable and timeout; the meter (slave)
// returns the measured period and status.
interface step_period_meter_if
  import step_motor_pkg::*;
#(
  parameter int WIDTH = STEP_CNT_WIDTH
);

  logic             pulse_in;
  logic             enable;
  logic [WIDTH-1:0] timeout_cycles;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             stalled;
  logic             measuring;

  modport master (
    output pulse_in,
    output enable,
    output timeout_cycles,
    input  period,
    input  period_valid,
    input  stalled,
    input  measuring
  );

  modport slave (
    input  pulse_in,
    input  enable,
    input  timeout_cycles,
    output period,
    output period_valid,
    output stalled,
    output measuring
  );

endinterface

// File: rtl/pulse_sync_edge.sv
// Brings an asynchronous pulse into the clk domain through a flop chain and
// flags its rising edges. SYNC_STAGES must be at least 2 so the first flop
// has a full cycle to resolve metastability before the level is used.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the raw pulse through the synchronizer chain every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pulse_in};
    end
  end

  // Keep the previous synchronized sample for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/step_period_meter.sv
// Measures the number of clk cycles between consecutive rising edges of an
// asynchronous pulse, reports each completed interval with a one-cycle
// strobe, and flags a stall when no edge arrives within the timeout or the
// counter would overflow.
module step_period_meter
  import step_motor_pkg::*;
#(
  parameter int WIDTH       = STEP_CNT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  step_period_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic             level_s;
  logic             rise_s;
  logic             edge_s;
  logic             timeout_hit_s;
  logic             sat_hit_s;

  meter_state_t     state_r;
  meter_state_t     state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] period_nxt_s;
  logic             period_valid_r;
  logic             period_valid_nxt_s;
  logic             stalled_r;
  logic             stalled_nxt_s;
  logic             measuring_r;

  // The synchronizer keeps running while disabled so that re-enabling
  // with the pulse already high cannot produce a false edge.
  pulse_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (bus.pulse_in),
    .level    (level_s),
    .rise     (rise_s)
  );

  // A rise always coincides with a high level; qualifying with it keeps the
  // edge tied to the sample that actually counts as the pulse.
  assign edge_s = rise_s & level_s;

  // Timeout is compared for equality every cycle, so a new timeout value
  // applies to the interval already in progress.
  assign timeout_hit_s = (bus.timeout_cycles != CNT_ZERO) && (count_r == bus.timeout_cycles);
  assign sat_hit_s     = (count_r == CNT_MAX);

  // Next-state, counter and output decisions
  always_comb begin
    state_nxt_s        = state_r;
    count_nxt_s        = count_r;
    period_nxt_s       = period_r;
    period_valid_nxt_s = 1'b0;
    stalled_nxt_s      = stalled_r;

    if (!bus.enable) begin
      state_nxt_s   = IDLE;
      count_nxt_s   = CNT_ZERO;
      stalled_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = ARM;
        end

        ARM: begin
          // First edge only establishes the reference point
          if (edge_s) begin
            state_nxt_s = MEASURE;
            count_nxt_s = CNT_ONE;
          end else begin
            state_nxt_s = ARM;
          end
        end

        MEASURE: begin
          // An edge wins over a timeout landing in the same cycle
          if (edge_s) begin
            period_nxt_s       = count_r;
            period_valid_nxt_s = 1'b1;
            count_nxt_s        = CNT_ONE;
          end else if (timeout_hit_s) begin
            state_nxt_s   = STALL;
            stalled_nxt_s = 1'b1;
          end else if (sat_hit_s) begin
            state_nxt_s   = STALL;
            stalled_nxt_s = 1'b1;
          end else begin
            count_nxt_s = count_r + CNT_ONE;
          end
        end

        STALL: begin
          // The stalled interval has no known length, so nothing is reported
          if (edge_s) begin
            state_nxt_s   = MEASURE;
            count_nxt_s   = CNT_ONE;
            stalled_nxt_s = 1'b0;
          end else begin
            state_nxt_s = STALL;
          end
        end

        default: begin
          state_nxt_s   = IDLE;
          count_nxt_s   = CNT_ZERO;
          stalled_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      count_r        <= CNT_ZERO;
      period_r       <= CNT_ZERO;
      period_valid_r <= 1'b0;
      stalled_r      <= 1'b0;
      measuring_r    <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      count_r        <= count_nxt_s;
      period_r       <= period_nxt_s;
      period_valid_r <= period_valid_nxt_s;
      stalled_r      <= stalled_nxt_s;
      measuring_r    <= (state_nxt_s == MEASURE);
    end
  end

  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;
  assign bus.stalled      = stalled_r;
  assign bus.measuring    = measuring_r;

endmodule

// File: tb/tb_step_period_meter.sv
// Randomized self-checking bench for step_period_meter. A reference model
// built from edge timestamps predicts every output each cycle; directed
// checks cover strobe counts, stall latency, enable/reset and saturation.
module tb_step_period_meter;
  import step_motor_pkg::*;

  localparam int W  = 32;
  localparam int W8 = 8;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #10 clk = ~clk;

  step_period_meter_if #(.WIDTH(W))  bus  ();
  step_period_meter_if #(.WIDTH(W8)) bus8 ();

  step_period_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  step_period_meter #(.WIDTH(W8), .SYNC_STAGES(S)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  // Reference model: sample history plus timestamp of the last counted edge
  bit           hist[$];
  bit           m_active;
  longint       m_ref;
  bit           m_stall;
  logic [W-1:0] m_period;
  bit           m_valid;
  bit           m_meas;

  // Observation bookkeeping
  bit     samp_prev     = 1'b0;
  longint last_rise_k   = 0;
  bit     obs_stall_prev = 1'b0;
  int     n_valid       = 0;
  int     n_stall_rise  = 0;
  longint dut_stall_lat = -1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < S + 2; i++) hist.push_back(1'b0);
    m_active = 1'b0;
    m_ref    = -1;
    m_stall  = 1'b0;
    m_period = '0;
    m_valid  = 1'b0;
    m_meas   = 1'b0;
  endfunction

  // One clock edge of the model: p is the pulse sampled at this edge
  function automatic void model_step(bit p, bit en, logic [W-1:0] tmo);
    bit     rise_reg;
    longint elapsed;
    hist.push_back(p);
    if (hist.size() > 16) void'(hist.pop_front());
    // A pulse first sampled high S edges ago is registered as an edge now
    rise_reg = hist[hist.size()-1-S] && !hist[hist.size()-2-S];
    m_valid = 1'b0;
    if (!en) begin
      m_active = 1'b0;
      m_ref    = -1;
      m_stall  = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
    end else if (rise_reg) begin
      if (m_ref >= 0 && !m_stall) begin
        m_period = W'(cyc - m_ref);
        m_valid  = 1'b1;
      end
      m_ref   = cyc;
      m_stall = 1'b0;
    end else if (m_ref >= 0 && !m_stall) begin
      elapsed = cyc - m_ref;
      if ((tmo != '0 && longint'(tmo) == elapsed) || elapsed == ((longint'(1) << W) - 1))
        m_stall = 1'b1;
    end
    m_meas = m_active && (m_ref >= 0) && !m_stall;
  endfunction

  // Advance one clock, update the model and compare all outputs
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (bus.pulse_in && !samp_prev) last_rise_k = cyc;
    samp_prev = bus.pulse_in;
    if (!rst_n) model_reset();
    else model_step(bus.pulse_in, bus.enable, bus.timeout_cycles);
    #1;
    check_val("period",       64'(bus.period),       64'(m_period));
    check_val("period_valid", 64'(bus.period_valid), 64'(m_valid));
    check_val("stalled",      64'(bus.stalled),      64'(m_stall));
    check_val("measuring",    64'(bus.measuring),    64'(m_meas));
    if (bus.stalled && !obs_stall_prev) begin
      n_stall_rise++;
      dut_stall_lat = cyc - (last_rise_k + S - 1);
    end
    obs_stall_prev = bus.stalled;
    if (bus.period_valid) n_valid++;
  endtask

  task automatic run_pulses(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < per; i++) begin
        bus.pulse_in = (i < hi);
        tick();
      end
    end
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pulse_in = 1'b0;
      tick();
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint k8;
    longint meas8_cyc;
    longint st8_cyc;
    int     valid8;
    int     per;
    int     hi;

    rst_n = 1'b0;
    bus.pulse_in = 1'b0;
    bus.enable = 1'b0;
    bus.timeout_cycles = '0;
    bus8.pulse_in = 1'b0;
    bus8.enable = 1'b0;
    bus8.timeout_cycles = '0;
    model_reset();

    // Reset state
    #3;
    check_val("rst_period",    64'(bus.period),        64'd0);
    check_val("rst_valid",     64'(bus.period_valid),  64'd0);
    check_val("rst_stalled",   64'(bus.stalled),       64'd0);
    check_val("rst_measuring", 64'(bus.measuring),     64'd0);
    check_val("rst8_period",   64'(bus8.period),       64'd0);
    check_val("rst8_measuring", 64'(bus8.measuring),   64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Steady rate: 8 rises, 100 apart, 7 reported intervals
    bus.enable = 1'b1;
    bus.timeout_cycles = 32'd1000;
    idle_low(5);
    n_valid = 0;
    run_pulses(100, 50, 8);
    check_val("steady_strobes", 64'(n_valid), 64'd7);
    check_val("steady_period",  64'(bus.period), 64'd100);

    // Stall: no pulses with a 500-cycle timeout
    bus.timeout_cycles = 32'd500;
    n_stall_rise = 0;
    idle_low(600);
    check_val("stall_count",   64'(n_stall_rise), 64'd1);
    check_val("stall_latency", 64'(dut_stall_lat), 64'd501);
    check_val("stall_period_held", 64'(bus.period), 64'd100);

    // Recovery: first rise clears stall silently, later rises report
    n_valid = 0;
    run_pulses(100, 50, 4);
    check_val("recover_strobes", 64'(n_valid), 64'd3);
    check_val("recover_stalled", 64'(bus.stalled), 64'd0);

    // Boundary: interval equal to the timeout never stalls
    bus.timeout_cycles = 32'd100;
    n_valid = 0;
    n_stall_rise = 0;
    run_pulses(100, 50, 6);
    check_val("bound_strobes", 64'(n_valid), 64'd6);
    check_val("bound_stalls",  64'(n_stall_rise), 64'd0);

    // One past the timeout stalls on every 101-cycle interval
    n_valid = 0;
    n_stall_rise = 0;
    run_pulses(101, 50, 4);
    check_val("over_strobes", 64'(n_valid), 64'd1);
    check_val("over_stalls",  64'(n_stall_rise), 64'd3);

    // Enable dropped mid-interval, re-enabled while the pulse is high
    bus.timeout_cycles = 32'd1000;
    run_pulses(80, 40, 3);
    for (int i = 0; i < 60; i++) begin
      bus.pulse_in = (i < 40);
      tick();
    end
    n_valid = 0;
    bus.enable = 1'b0;
    tick();
    check_val("dis_measuring", 64'(bus.measuring), 64'd0);
    check_val("dis_stalled",   64'(bus.stalled),   64'd0);
    bus.pulse_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_val("reen_no_false_edge", 64'(bus.measuring), 64'd0);
    idle_low(30);
    run_pulses(90, 45, 3);
    check_val("reen_strobes", 64'(n_valid), 64'd2);
    check_val("reen_period",  64'(bus.period), 64'd90);

    // Asynchronous reset mid-interval
    run_pulses(70, 35, 3);
    bus.pulse_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_period",    64'(bus.period),       64'd0);
    check_val("arst_valid",     64'(bus.period_valid), 64'd0);
    check_val("arst_stalled",   64'(bus.stalled),      64'd0);
    check_val("arst_measuring", 64'(bus.measuring),    64'd0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    idle_low(5);
    run_pulses(70, 35, 3);

    // Randomized bursts, timeouts, gaps and enable drops
    for (int b = 0; b < 14; b++) begin
      per = int'($urandom_range(2, 250));
      hi  = int'($urandom_range(1, per - 1));
      if ($urandom_range(0, 3) == 0) bus.timeout_cycles = '0;
      else bus.timeout_cycles = W'($urandom_range(2, 300));
      if ($urandom_range(0, 4) == 0) begin
        bus.enable = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) tick();
        bus.enable = 1'b1;
      end
      run_pulses(per, hi, int'($urandom_range(2, 5)));
      if ($urandom_range(0, 2) == 0) idle_low(int'($urandom_range(0, 400)));
    end

    // Saturation on an 8-bit meter with the timeout disabled
    bus.enable = 1'b0;
    bus.pulse_in = 1'b0;
    bus8.enable = 1'b1;
    bus8.timeout_cycles = 8'd0;
    bus8.pulse_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus8.pulse_in = 1'b1;
    tick();
    k8 = cyc;
    meas8_cyc = -1;
    st8_cyc = -1;
    valid8 = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 4) bus8.pulse_in = 1'b0;
      tick();
      if (bus8.measuring && meas8_cyc < 0) meas8_cyc = cyc;
      if (bus8.stalled && st8_cyc < 0) st8_cyc = cyc;
      if (bus8.period_valid) valid8++;
    end
    check_val("sat_measure_start", 64'(meas8_cyc - k8), 64'd2);
    check_val("sat_stall_time",    64'(st8_cyc - k8),   64'd257);
    check_val("sat_period",        64'(bus8.period),    64'd0);
    check_val("sat_strobes",       64'(valid8),         64'd0);
    check_val("sat_stalled_held",  64'(bus8.stalled),   64'd1);
    check_val("sat_measuring",     64'(bus8.measuring), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
